// File: rtl/aes128_round_ctrl_if.sv
// Handshake and shared-datapath bundle between the AES-128 round controller and its environment.
`timescale 1ns/1ps
interface aes128_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] rnd_in;
  logic         rnd_last;
  logic [127:0] rnd_out;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;

  // Environment side: supplies plaintext, round keys, the round datapath and the consumer.
  modport master (
    output in_valid, plain_text, rk, rnd_out, out_ready,
    input  in_ready, rk_idx, rnd_in, rnd_last, out_valid, cipher_text, busy
  );

  modport slave (
    input  in_valid, plain_text, rk, rnd_out, out_ready,
    output in_ready, rk_idx, rnd_in, rnd_last, out_valid, cipher_text, busy
  );
endinterface

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encrypt sequencer driving one shared combinational round datapath.
// Optional abort input is compiled in when AES_CTRL_ABORT_EN is defined.
`timescale 1ns/1ps
module aes128_round_ctrl (
  input  logic clk,
  input  logic reset,
`ifdef AES_CTRL_ABORT_EN
  input  logic abort,
`endif
  aes128_round_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_st;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;
  logic         r_rnd_last;

  logic         w_final_round;
  logic         w_abort;

  assign w_final_round = (r_rnd == 4'd10);

`ifdef AES_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // r_rnd is zero whenever not in ROUND, so it doubles as the key-store index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_rnd       <= 4'd0;
      r_st        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rnd_last  <= 1'b0;
    end else if (w_abort) begin
      r_state     <= S_IDLE;
      r_rnd       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rnd_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_st       <= bus.plain_text ^ bus.rk;
            r_rnd      <= 4'd1;
            r_state    <= S_ROUND;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_rnd_last <= 1'b0;
          end
        end

        S_ROUND: begin
          r_st <= bus.rnd_out;
          if (w_final_round) begin
            r_rnd       <= 4'd0;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_rnd_last  <= 1'b0;
          end else begin
            r_rnd      <= r_rnd + 4'd1;
            r_rnd_last <= (r_rnd == 4'd9);
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_rnd       <= 4'd0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_rnd_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.rk_idx      = r_rnd;
  assign bus.rnd_in      = r_st;
  assign bus.rnd_last    = r_rnd_last;
  assign bus.out_valid   = r_out_valid;
  assign bus.cipher_text = r_st;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl: behavioural AES-128 key store, round datapath and cycle model.
// Abort scenarios are included when AES_CTRL_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_aes128_round_ctrl;

  localparam logic [127:0] FIPS_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic reset;
  logic abortSig;
  int   nChecks = 0;
  int   nFail   = 0;

  logic [127:0] roundKeys [0:10];

  aes128_round_ctrl_if bus();

  aes128_round_ctrl dut (
    .clk   (clk),
    .reset (reset),
`ifdef AES_CTRL_ABORT_EN
    .abort (abortSig),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, base, inv;
    logic [7:0] e;
    r = 8'h01; base = a; e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    inv = (a == 8'h00) ? 8'h00 : r;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[4*c+r] = b[4*((c+r)%4)+r];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    return o ^ k;
  endfunction

  task automatic setKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox(tmp[31:24]) ^ rcon, sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) roundKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] modelEncrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ roundKeys[0];
    for (int r = 1; r <= 10; r++) s = aesRound(s, roundKeys[r], r == 10);
    return s;
  endfunction

  // External key store and shared round datapath seen by the controller.
  always_comb begin
    bus.rk = '0;
    for (int i = 0; i < 11; i++)
      if (bus.rk_idx == i[3:0]) bus.rk = roundKeys[i];
  end

  assign bus.rnd_out = aesRound(bus.rnd_in, bus.rk, bus.rnd_last);

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Cycle model: mPhase = 0 idle, 1..10 = cycles since accept while rounds run, 11 = result held.
  int           mPhase = 0;
  logic [127:0] mTrace [0:10];
  logic [127:0] mIdleSt = '0;

  always @(negedge clk) begin : compare
    logic [127:0] expSt;
    if (!reset) begin
      checkOutput("rst_in_ready", bus.in_ready, 1);
      checkOutput("rst_out_valid", bus.out_valid, 0);
      checkOutput("rst_busy", bus.busy, 0);
      checkOutput("rst_rnd_last", bus.rnd_last, 0);
      checkOutput("rst_rk_idx", bus.rk_idx, 0);
      checkOutput("rst_cipher", bus.cipher_text, 0);
      mPhase  = 0;
      mIdleSt = '0;
    end else begin
      if (mPhase == 0)       expSt = mIdleSt;
      else if (mPhase <= 10) expSt = mTrace[mPhase-1];
      else                   expSt = mTrace[10];
      checkOutput("in_ready", bus.in_ready, mPhase == 0);
      checkOutput("busy", bus.busy, mPhase != 0);
      checkOutput("out_valid", bus.out_valid, mPhase == 11);
      checkOutput("rk_idx", bus.rk_idx, (mPhase >= 1 && mPhase <= 10) ? mPhase : 0);
      checkOutput("rnd_last", bus.rnd_last, mPhase == 10);
      checkOutput("rnd_in", bus.rnd_in, expSt);
      checkOutput("cipher_text", bus.cipher_text, expSt);

      if (abortSig && mPhase != 0) begin
        mIdleSt = expSt;
        mPhase  = 0;
      end else if (mPhase == 0) begin
        if (bus.in_valid) begin
          mTrace[0] = bus.plain_text ^ roundKeys[0];
          for (int r = 1; r <= 10; r++) mTrace[r] = aesRound(mTrace[r-1], roundKeys[r], r == 10);
          mPhase = 1;
        end
      end else if (mPhase <= 10) begin
        mPhase = mPhase + 1;
      end else if (bus.out_ready) begin
        mIdleSt = mTrace[10];
        mPhase  = 0;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [127:0] pt, input bit keepValid, output int waited);
    bit accepted;
    accepted = 0;
    waited   = 0;
    bus.in_valid   = 1'b1;
    bus.plain_text = pt;
    while (!accepted && waited < 40) begin
      @(negedge clk);
      waited++;
      if (bus.in_ready) accepted = 1;
    end
    if (!accepted) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (!keepValid) bus.in_valid = 1'b0;
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 40);
  endtask

  task automatic waitRkIdx(input logic [3:0] target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.rk_idx != target && n < 40);
    if (bus.rk_idx != target) checkOutput("wait_rk_idx", bus.rk_idx, target);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited, lat, gap;
    logic [127:0] ptA, ptB;

    reset          = 1'b0;
    abortSig       = 1'b0;
    bus.in_valid   = 1'b0;
    bus.plain_text = '0;
    bus.out_ready  = 1'b1;
    setKey(FIPS_KEY);
    checkOutput("pin_rk10", roundKeys[10], FIPS_RK10);
    checkOutput("pin_model_ct", modelEncrypt(FIPS_PT), FIPS_CT);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    $display("[TB] FIPS-197 vector, accepted on first edge after reset");
    applyStimulus(FIPS_PT, 0, waited);
    checkOutput("accept_first_edge", waited, 1);
    waitOutValid(lat);
    checkOutput("latency", lat, 11);
    checkOutput("fips_ct", bus.cipher_text, FIPS_CT);

    $display("[TB] consumer stall in result state");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    applyStimulus(FIPS_PT, 0, waited);
    waitOutValid(lat);
    checkOutput("stall_latency", lat, 11);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_valid", bus.out_valid, 1);
      checkOutput("stall_ct", bus.cipher_text, FIPS_CT);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("idle_after_ready", {bus.in_ready, bus.out_valid}, 2'b10);

    $display("[TB] back-to-back blocks with in_valid held");
    ptA = {$urandom, $urandom, $urandom, $urandom};
    ptB = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    applyStimulus(ptA, 1, waited);
    bus.plain_text = ptB;
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bus.in_ready && gap < 40);
    checkOutput("block_period", gap, 12);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitOutValid(lat);
    checkOutput("b2b_latency", lat, 11);
    checkOutput("b2b_ct", bus.cipher_text, modelEncrypt(ptB));

    $display("[TB] reset pulse mid-block");
    @(posedge clk); #1;
    applyStimulus(FIPS_PT, 0, waited);
    waitRkIdx(4'd5);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_state",
                {bus.in_ready, bus.out_valid, bus.busy, bus.rnd_last, bus.rk_idx},
                {1'b1, 1'b0, 1'b0, 1'b0, 4'd0});
    checkOutput("async_rst_ct", bus.cipher_text, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(FIPS_PT, 0, waited);
    checkOutput("post_rst_first_edge", waited, 1);
    waitOutValid(lat);
    checkOutput("post_rst_latency", lat, 11);
    checkOutput("post_rst_ct", bus.cipher_text, FIPS_CT);

`ifdef AES_CTRL_ABORT_EN
    $display("[TB] abort during rounds and while idle");
    @(posedge clk); #1;
    applyStimulus(FIPS_PT, 0, waited);
    waitRkIdx(4'd2);
    @(posedge clk); #1;
    abortSig = 1'b1;
    @(posedge clk); #1;
    abortSig = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", {bus.in_ready, bus.out_valid, bus.busy, bus.rk_idx},
                {1'b1, 1'b0, 1'b0, 4'd0});
    @(posedge clk); #1;
    abortSig = 1'b1;
    applyStimulus(FIPS_PT, 0, waited);
    abortSig = 1'b0;
    checkOutput("abort_in_idle_accept", waited, 1);
    waitOutValid(lat);
    checkOutput("abort_next_latency", lat, 11);
    checkOutput("abort_next_ct", bus.cipher_text, FIPS_CT);
`endif

    $display("[TB] randomized traffic with a random key");
    @(posedge clk); #1;
    @(posedge clk); #1;
    setKey({$urandom, $urandom, $urandom, $urandom});
    for (int cyc = 0; cyc < 900; cyc++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.plain_text = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready  = ($urandom_range(0, 3) != 0);
`ifdef AES_CTRL_ABORT_EN
      abortSig = ($urandom_range(0, 15) == 0);
`endif
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 199) == 0) reset = 1'b0;
      @(posedge clk); #1;
    end
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    abortSig      = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/aes128_round_ctrl.md
AES128_ROUND_CTRL -- requirements
Module: aes128_round_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port in_valid  input  1  plaintext block offered.
REQ-004 SHALL have port in_ready  output  1  controller accepts a block this cycle.
REQ-005 SHALL have port plain_text  input  128  plaintext, sampled on in_valid&&in_ready.
REQ-006 SHALL have port rk_idx  output  4  round-key index requested from the external key store (0..10).
REQ-007 SHALL have port rk  input  128  round key for rk_idx, combinationally valid in the same cycle.
REQ-008 SHALL have port rnd_in  output  128  state driven into the shared combinational encrypt round.
REQ-009 SHALL have port rnd_last  output  1  final round; the datapath omits MixColumns.
REQ-010 SHALL have port rnd_out  input  128  round result returned by the datapath.
REQ-011 SHALL have port out_valid  output  1  ciphertext available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the ciphertext.
REQ-013 SHALL have port cipher_text  output  128  result; stable while out_valid=1.
REQ-014 SHALL have port busy  output  1  high in ROUND and DONE.

Function
REQ-015 SHALL implement the FSM IDLE -> ROUND -> DONE -> IDLE, with a 4-bit round counter rnd and a 128-bit state register st.
REQ-016 In IDLE: in_ready=1, rk_idx=0; on in_valid=1, st <= plain_text XOR rk (initial AddRoundKey), rnd <= 1, next ROUND.
REQ-017 In ROUND: rk_idx=rnd, rnd_in=st, rnd_last=(rnd==10), st <= rnd_out every cycle, rnd <= rnd+1.
REQ-018 In ROUND with rnd==10: next state is DONE and rnd <= 0; rnd SHALL never exceed 10.
REQ-019 In DONE: out_valid=1, cipher_text=st; on out_ready=1, next IDLE; otherwise hold st and out_valid.
REQ-020 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored.
REQ-021 Latency SHALL be exactly 11 cycles from the accept edge to out_valid=1; minimum block period SHALL be 12 cycles.
REQ-022 rnd_last SHALL be 0 outside ROUND; rk_idx SHALL be 0 in IDLE and DONE.
REQ-023 cipher_text SHALL equal st at all times; rnd_in SHALL equal st at all times.
REQ-024 out_ready outside DONE SHALL have no effect.

Reset
REQ-025 While reset=0: state IDLE, rnd=0, st=0, in_ready=1, out_valid=0, busy=0, rnd_last=0, rk_idx=0, cipher_text=0.
REQ-026 Reset asserted mid-operation SHALL abandon the block immediately; no out_valid for that block after release.
REQ-027 After reset deasserts, a block SHALL be acceptable on the first rising edge.

Configuration
REQ-028 Macro AES_CTRL_ABORT_EN, when defined, SHALL add port abort  input  1.
REQ-029 With AES_CTRL_ABORT_EN: abort=1 in ROUND or DONE SHALL force IDLE, rnd=0, and out_valid=0 on the next edge; st is retained; abort in IDLE SHALL have no effect and SHALL not block acceptance.
REQ-030 Without AES_CTRL_ABORT_EN: the abort port SHALL be absent and behaviour SHALL follow REQ-015..REQ-027 only.

Verification
REQ-031 The bench key model SHALL serve the FIPS-197 schedule for key 000102030405060708090a0b0c0d0e0f; plain_text 00112233445566778899aabbccddeeff -> out_valid exactly 11 cycles after accept, cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 Same vector with out_ready=0 for 5 cycles in DONE -> out_valid and cipher_text held for all 5 cycles; IDLE one cycle after out_ready=1.
REQ-033 in_valid held at 1 with two queued blocks -> second accepted exactly 12 cycles after the first with out_ready=1; rk_idx sequence 0,1,2,...,10,0 per block; rnd_last=1 only at rk_idx=10.
REQ-034 reset=0 pulsed during the round with rk_idx=5 -> all outputs at reset values immediately; out_valid never rises for that block; new vector after release yields the correct ciphertext.
REQ-035 With AES_CTRL_ABORT_EN, abort=1 at rk_idx=3 -> IDLE next edge, in_ready=1, no out_valid; the following block encrypts correctly. Without the macro, a build with no abort port passes REQ-031.
